// File: rtl/adder_err_accum_pkg.sv
// Shared types and default widths for the adder error accumulator.
package adder_err_accum_pkg;

  localparam int W_DEF     = 128;
  localparam int CNT_W_DEF = 32;

  // sum_ed must hold 2^CNT_W samples of a (W+1)-bit distance without wrapping
  function automatic int acc_w(input int w, input int cnt_w);
    return w + 1 + cnt_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_err_accum_if.sv
// Result stream from the adder under test: approx/exact pair with valid/ready.
interface adder_err_accum_if #(
  parameter int W = adder_err_accum_pkg::W_DEF
);
  logic       in_valid;
  logic       in_ready;
  logic [W:0] approx;
  logic [W:0] exact;

  modport master (output in_valid, output approx, output exact, input in_ready);
  modport slave  (input in_valid, input approx, input exact, output in_ready);
endinterface

// File: rtl/adder_err_dist.sv
// Error-distance datapath: registers the signed difference and mismatch flag.
// Latency: 1 cycle to the registered diff; ed is the combinational abs of that register.
// Backpressure: none, a pair is captured whenever acc is high.
module adder_err_dist #(
  parameter int W = adder_err_accum_pkg::W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       acc,
  input  logic [W:0] approx,
  input  logic [W:0] exact,
  output logic       s1_vld,
  output logic       neq,
  output logic [W:0] ed
);
  localparam int EW = W + 1;

  logic [W+1:0] d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      neq    <= 1'b0;
      d      <= '0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        d   <= {1'b0, approx} - {1'b0, exact};
        neq <= (approx != exact);
      end
    end
  end

  // |d| always fits in W+1 bits, so the low bits of the negation are exact
  assign ed = d[W+1] ? (~d[W:0] + EW'(1)) : d[W:0];

endmodule

// File: rtl/adder_err_accum.sv
// Run controller and error statistics for an approximate adder result stream.
// Latency: stats include a pair one edge after its accept; done two edges after the last accept.
// Backpressure: in_ready only while running; pairs outside RUN are ignored.
module adder_err_accum #(
  parameter int W     = adder_err_accum_pkg::W_DEF,
  parameter int CNT_W = adder_err_accum_pkg::CNT_W_DEF,
  parameter int ACC_W = adder_err_accum_pkg::acc_w(W, CNT_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  adder_err_accum_if.slave     s,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [W:0]           max_ed,
  output logic [ACC_W-1:0]     sum_ed,
  output logic                 sat
);
  import adder_err_accum_pkg::*;

  localparam int AW1 = ACC_W + 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] rem;
  logic             acc, last, start_ok;
  logic             s1_vld, s1_neq;
  logic [W:0]       ed;
  logic [ACC_W:0]   sum_nx;

  assign s.in_ready = (state == RUN);
  assign acc        = s.in_valid & s.in_ready;
  assign last       = acc && (rem == CNT_W'(1));
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign sum_nx     = {1'b0, sum_ed} + AW1'(ed);

  adder_err_dist #(.W(W)) u_dist (
    .clk    (clk),
    .rst    (rst),
    .acc    (acc),
    .approx (s.approx),
    .exact  (s.exact),
    .s1_vld (s1_vld),
    .neq    (s1_neq),
    .ed     (ed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (n_samples == '0) ? DRAIN : RUN;
      RUN:        if (last) state_nx = DRAIN;
      DRAIN:      if (!s1_vld) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem        <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
      sat        <= 1'b0;
    end else if (start_ok) begin
      rem        <= n_samples;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
      sat        <= 1'b0;
    end else begin
      if (acc) begin
        rem        <= rem - CNT_W'(1);
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if (s1_vld) begin
        err_cnt <= err_cnt + CNT_W'(s1_neq);
        if (ed > max_ed) max_ed <= ed;
        // once saturated, further adds either stay at all-ones or overflow back to it
        if (sum_nx[ACC_W]) begin
          sum_ed <= '1;
          sat    <= 1'b1;
        end else begin
          sum_ed <= sum_nx[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_err_accum.sv
// Directed bench for adder_err_accum: default instance plus a narrow-accumulator instance for saturation.
module tb_adder_err_accum;
  localparam int W     = 128;
  localparam int CNT_W = 32;
  localparam int ACC_W = W + 1 + CNT_W;
  localparam int SAT_W = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start, start_s;
  logic [CNT_W-1:0] n_samples, n_s;

  logic             busy, done, sat;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [W:0]       max_ed;
  logic [ACC_W-1:0] sum_ed;

  logic             busy_s, done_s, sat_s;
  logic [CNT_W-1:0] sample_cnt_s, err_cnt_s;
  logic [W:0]       max_ed_s;
  logic [SAT_W-1:0] sum_ed_s;

  adder_err_accum_if #(.W(W)) bus ();
  adder_err_accum_if #(.W(W)) bus_s ();

  adder_err_accum #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .s(bus),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_ed(max_ed), .sum_ed(sum_ed), .sat(sat)
  );

  adder_err_accum #(.W(W), .CNT_W(CNT_W), .ACC_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .n_samples(n_s), .s(bus_s),
    .busy(busy_s), .done(done_s), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s),
    .max_ed(max_ed_s), .sum_ed(sum_ed_s), .sat(sat_s)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [191:0] exp_v;
  logic [W:0]   top_bit;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [CNT_W-1:0] n);
    n_samples = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic feed(input logic [W:0] a, input logic [W:0] e);
    bus.in_valid = 1'b1;
    bus.approx   = a;
    bus.exact    = e;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic feed_s(input logic [W:0] a, input logic [W:0] e);
    bus_s.in_valid = 1'b1;
    bus_s.approx   = a;
    bus_s.exact    = e;
    tick();
    bus_s.in_valid = 1'b0;
  endtask

  initial begin
    start = 1'b0; start_s = 1'b0; n_samples = '0; n_s = '0;
    bus.in_valid = 1'b0; bus.approx = '0; bus.exact = '0;
    bus_s.in_valid = 1'b0; bus_s.approx = '0; bus_s.exact = '0;
    top_bit = '0;
    top_bit[W] = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_sum", sum_ed, 0);
    rst = 1'b0;
    tick();

    // exact match, n=4
    pulse(4);
    chk("ex_busy", busy, 1);
    chk("ex_ready", bus.in_ready, 1);
    for (int i = 0; i < 4; i++) feed(129'(i * 5 + 1), 129'(i * 5 + 1));
    chk("ex_ready_drop", bus.in_ready, 0);
    chk("ex_cnt_at_last", sample_cnt, 4);
    tick();
    chk("ex_done_k1", done, 0);
    tick();
    chk("ex_done_k2", done, 1);
    chk("ex_busy_end", busy, 0);
    chk("ex_err", err_cnt, 0);
    chk("ex_max", max_ed, 0);
    chk("ex_sum", sum_ed, 0);

    // mixed errors, restarted from DONE
    pulse(3);
    chk("mx_done_clr", done, 0);
    chk("mx_cnt_clr", sample_cnt, 0);
    feed(10, 7);
    feed(7, 10);
    feed(5, 5);
    tick();
    tick();
    chk("mx_done", done, 1);
    chk("mx_cnt", sample_cnt, 3);
    chk("mx_err", err_cnt, 2);
    chk("mx_max", max_ed, 3);
    chk("mx_sum", sum_ed, 6);

    // carry-bit only error
    pulse(1);
    feed(top_bit, 0);
    tick();
    tick();
    exp_v = 192'd1 << 128;
    chk("cy_done", done, 1);
    chk("cy_err", err_cnt, 1);
    chk("cy_max", max_ed, exp_v);
    chk("cy_sum", sum_ed, exp_v);

    // gaps and overrun, n=2
    pulse(2);
    feed(3, 1);
    tick();
    chk("gp_cnt_gap", sample_cnt, 1);
    feed(1, 1);
    chk("gp_ready_drop", bus.in_ready, 0);
    bus.in_valid = 1'b1; bus.approx = 100; bus.exact = 0;
    tick();
    bus.in_valid = 1'b0;
    chk("gp_done_k1", done, 0);
    tick();
    chk("gp_done", done, 1);
    chk("gp_cnt", sample_cnt, 2);
    chk("gp_err", err_cnt, 1);
    chk("gp_max", max_ed, 2);
    chk("gp_sum", sum_ed, 2);

    // saturation on the narrow accumulator
    n_s = 4;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 4; i++) feed_s(top_bit, 0);
    exp_v = 192'd3 << 128;
    chk("st_sum_3", sum_ed_s, exp_v);
    chk("st_sat_3", sat_s, 0);
    tick();
    exp_v = (192'd1 << SAT_W) - 192'd1;
    chk("st_sum_sat", sum_ed_s, exp_v);
    chk("st_sat", sat_s, 1);
    tick();
    chk("st_done", done_s, 1);

    // n_samples == 0
    pulse(0);
    chk("z_busy", busy, 1);
    chk("z_done_k1", done, 0);
    tick();
    chk("z_done", done, 1);
    chk("z_cnt", sample_cnt, 0);
    chk("z_max", max_ed, 0);
    chk("z_sum", sum_ed, 0);

    // start while busy is ignored
    pulse(3);
    feed(4, 1);
    pulse(1);
    chk("sb_cnt", sample_cnt, 1);
    chk("sb_busy", busy, 1);
    chk("sb_sum", sum_ed, 3);
    feed(1, 1);
    chk("sb_ready_mid", bus.in_ready, 1);
    feed(1, 1);
    tick();
    tick();
    chk("sb_done", done, 1);
    chk("sb_cnt_end", sample_cnt, 3);
    chk("sb_err", err_cnt, 1);

    // asynchronous reset mid-run
    pulse(5);
    feed(9, 1);
    feed(9, 1);
    chk("ar_pre_cnt", sample_cnt, 2);
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ready", bus.in_ready, 0);
    chk("ar_done", done, 0);
    chk("ar_cnt", sample_cnt, 0);
    chk("ar_err", err_cnt, 0);
    chk("ar_max", max_ed, 0);
    chk("ar_sum", sum_ed, 0);
    chk("ar_sat_s", sat_s, 0);
    rst = 1'b0;
    tick();
    chk("ar_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
